prefetch_fetch_unit: RTL and testbench

- Parametrised instruction fetch engine that assembles INSTR_WIDTH-bit instructions from MEM_WIDTH-bit beats of an external single-port read memory.
- Runs ahead of the control unit into a FIFO_DEPTH-entry instruction queue, delivered over a valid/ready handshake.
- Supports PC redirect (jump/loop), with flush of queued and in-flight data, and a stop command.
- Sits between the instruction DRAM model and the top-level decoder/controller.

---
 rtl/prefetch_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_prefetch_fetch_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fetch_unit.sv
// Instruction prefetch engine: assembles INSTR_WIDTH-bit instructions from MEM_WIDTH-bit memory beats
// into a FIFO_DEPTH-entry queue. Define FETCH_PERF_CNT_EN to add the perf_instr_o/perf_stall_o counters.
module prefetch_fetch_unit #(
    parameter int ADDR_WIDTH  = 24,
    parameter int INSTR_WIDTH = 64,
    parameter int MEM_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  start_pc_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    input  logic                   stop_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    output logic                   mem_rd_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic [MEM_WIDTH-1:0]   mem_rdata_i,
    output logic                   busy_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_instr_o,
    output logic [31:0]            perf_stall_o
`endif
);

    localparam int BEATS  = INSTR_WIDTH / MEM_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  asm_pc;
    logic                   iss_active;
    logic [BEAT_W-1:0]      iss_beat;
    logic                   cap_valid;
    logic [BEAT_W-1:0]      cap_beat;
    logic [INSTR_WIDTH-1:0] asm_data;
    logic [INSTR_WIDTH-1:0] asm_full;

    logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic              flush;
    logic              cap_last;
    logic              can_begin;
    logic              issue;
    logic [BEAT_W-1:0] beat_idx;
    logic              push;
    logic              pop;

    // An assembly still waiting for its last beat occupies a queue slot when deciding to begin another.
    assign flush     = (state == RUN) && (redirect_i || stop_i);
    assign cap_last  = cap_valid && (cap_beat == BEAT_W'(BEATS - 1));
    assign can_begin = (state == RUN) && !flush && !iss_active
                       && ((int'(count) + int'(cap_last)) < FIFO_DEPTH);
    assign issue     = (state == RUN) && !flush && (iss_active || can_begin);
    assign beat_idx  = iss_active ? iss_beat : '0;
    assign pop       = instr_valid_o && instr_ready_i && !flush;
    assign push      = cap_last && !flush && ((count != CNT_W'(FIFO_DEPTH)) || pop);

    always_comb begin
        // NOTE: default assignment first so the partial update below cannot infer a latch.
        asm_full = asm_data;
        asm_full[(BEATS - 1 - int'(cap_beat)) * MEM_WIDTH +: MEM_WIDTH] = mem_rdata_i;
    end

    assign instr_valid_o = (count != '0);
    assign instr_o       = fifo_instr[rd_ptr];
    assign instr_pc_o    = fifo_pc[rd_ptr];
    assign mem_rd_o      = issue;
    assign mem_addr_o    = pc;
    assign busy_o        = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= '0;
            asm_pc     <= '0;
            iss_active <= 1'b0;
            iss_beat   <= '0;
            cap_valid  <= 1'b0;
            cap_beat   <= '0;
            asm_data   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            // NOTE: the queue storage is cleared too, so instr_o/instr_pc_o read 0 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            // NOTE: every state register uses non-blocking assignment so all reads see pre-edge values.
            cap_valid <= issue;
            cap_beat  <= beat_idx;
            if (cap_valid && !flush) begin
                asm_data <= asm_full;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= RUN;
                        pc    <= start_pc_i;
                    end
                end
                RUN: begin
                    if (flush) begin
                        iss_active <= 1'b0;
                        iss_beat   <= '0;
                        if (stop_i) begin
                            state <= IDLE;
                        end else begin
                            pc <= redirect_pc_i;
                        end
                    end else if (issue) begin
                        pc         <= pc + ADDR_WIDTH'(1);
                        iss_active <= (beat_idx != BEAT_W'(BEATS - 1));
                        iss_beat   <= beat_idx + BEAT_W'(1);
                        if (beat_idx == '0) begin
                            asm_pc <= pc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo_instr[wr_ptr] <= asm_full;
                    fifo_pc[wr_ptr]    <= asm_pc;
                    wr_ptr             <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_cycle;
    assign stall_cycle = (state == RUN) && !flush && !issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_instr_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (pop && (perf_instr_o != '1)) begin
                perf_instr_o <= perf_instr_o + 32'd1;
            end
            if (stall_cycle && (perf_stall_o != '1)) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Self-checking bench for prefetch_fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based reference model.
module tb_prefetch_fetch_unit;

    localparam int AW    = 24;
    localparam int IW    = 64;
    localparam int MW    = 8;
    localparam int DEPTH = 4;
    localparam int BEATS = IW / MW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] start_pc_i = '0;
    logic          redirect_i = 1'b0;
    logic [AW-1:0] redirect_pc_i = '0;
    logic          stop_i = 1'b0;
    logic          instr_ready_i = 1'b1;
    logic [MW-1:0] mem_rdata_i = '0;
    logic          instr_valid_o;
    logic [IW-1:0] instr_o;
    logic [AW-1:0] instr_pc_o;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic          busy_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_instr_o;
    logic [31:0]   perf_stall_o;
`endif

    prefetch_fetch_unit #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .MEM_WIDTH(MW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .start_i(start_i), .start_pc_i(start_pc_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .stop_i(stop_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
`ifdef FETCH_PERF_CNT_EN
        , .perf_instr_o(perf_instr_o), .perf_stall_o(perf_stall_o)
`endif
    );

    // Second instance: 32-bit memory beats, two beats per instruction.
    logic          b_start = 1'b0;
    logic          b_ready = 1'b1;
    logic [31:0]   b_mem_rdata = '0;
    logic          b_valid;
    logic [IW-1:0] b_instr;
    logic [AW-1:0] b_instr_pc;
    logic          b_mem_rd;
    logic [AW-1:0] b_mem_addr;
    logic          b_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   b_perf_instr;
    logic [31:0]   b_perf_stall;
`endif

    prefetch_fetch_unit #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .MEM_WIDTH(32), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rst(rst),
        .start_i(b_start), .start_pc_i(24'h0),
        .redirect_i(1'b0), .redirect_pc_i(24'h0),
        .stop_i(1'b0),
        .instr_valid_o(b_valid), .instr_ready_i(b_ready),
        .instr_o(b_instr), .instr_pc_o(b_instr_pc),
        .mem_rd_o(b_mem_rd), .mem_addr_o(b_mem_addr), .mem_rdata_i(b_mem_rdata),
        .busy_o(b_busy)
`ifdef FETCH_PERF_CNT_EN
        , .perf_instr_o(b_perf_instr), .perf_stall_o(b_perf_stall)
`endif
    );

    // Memory contents: word a holds (a + 0x10) mod 256, so words 0..15 are 0x10..0x1F.
    function automatic logic [7:0] memf(input logic [AW-1:0] a);
        return 8'(a + 24'h10);
    endfunction

    function automatic logic [31:0] memf_b(input logic [AW-1:0] a);
        if (a == 24'd0) return 32'hAABBCCDD;
        if (a == 24'd1) return 32'h11223344;
        return {8'hEE, a};
    endfunction

    // First beat lands in the MSBs.
    function automatic logic [IW-1:0] instr_at(input logic [AW-1:0] p);
        logic [IW-1:0] r = '0;
        for (int k = 0; k < BEATS; k++) r = {r[IW-MW-1:0], memf(p + AW'(k))};
        return r;
    endfunction

    // Memories answer one cycle after the read; idle cycles return junk.
    always @(posedge clk) begin
        mem_rdata_i <= mem_rd_o ? memf(mem_addr_o) : 8'($urandom);
        b_mem_rdata <= b_mem_rd ? memf_b(b_mem_addr) : $urandom;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: instruction queue plus a notion of the assembly being fetched.
    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t      m_q[$];
    bit          m_on = 1'b0;
    bit          m_run = 1'b0;
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] m_asm_pc = '0;
    logic [AW-1:0] m_pend_pc = '0;
    int          m_left = 0;
    bit          m_pend = 1'b0;
    int unsigned m_pops = 0;

    function automatic bit m_flush();
        return m_run && (redirect_i || stop_i);
    endfunction

    function automatic bit m_rd();
        if (!m_run || m_flush()) return 1'b0;
        if (m_left > 0) return 1'b1;
        return (m_q.size() + int'(m_pend)) < DEPTH;
    endfunction

    // Compare on the falling edge, then advance the model by the rising edge to come.
    always @(negedge clk) begin
        bit rd;
        if (m_on) begin
            check("valid", instr_valid_o, m_q.size() > 0);
            if (m_q.size() > 0) begin
                check("instr", instr_o, m_q[0].instr);
                check("instr_pc", instr_pc_o, m_q[0].pc);
            end
            rd = m_rd();
            check("mem_rd", mem_rd_o, rd);
            if (rd) check("mem_addr", mem_addr_o, m_pc);
            check("busy", busy_o, m_run);
`ifdef FETCH_PERF_CNT_EN
            check("perf_instr", perf_instr_o, m_pops);
`endif
        end

        if (rst) begin
            m_on = 1'b1; m_run = 1'b0; m_q.delete(); m_left = 0; m_pend = 1'b0;
            m_pc = '0; m_pops = 0;
        end else if (!m_run) begin
            if (start_i) begin
                m_run = 1'b1;
                m_pc  = start_pc_i;
            end
        end else if (m_flush()) begin
            m_q.delete(); m_left = 0; m_pend = 1'b0;
            if (stop_i) m_run = 1'b0;
            else m_pc = redirect_pc_i;
        end else begin
            rd = m_rd();
            if (m_q.size() > 0 && instr_ready_i) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            if (m_pend) m_q.push_back('{instr: instr_at(m_pend_pc), pc: m_pend_pc});
            m_pend = 1'b0;
            if (rd) begin
                if (m_left == 0) begin
                    m_asm_pc = m_pc;
                    m_left   = BEATS;
                end
                m_left--;
                m_pc++;
                if (m_left == 0) begin
                    m_pend    = 1'b1;
                    m_pend_pc = m_asm_pc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic go_idle();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            cnt;
        logic [AW-1:0] wrap_exp [8];
        bit            low_phase;

        wrap_exp = '{24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF,
                     24'h000000, 24'h000001, 24'h000002, 24'h000003};

        // Reset state.
        repeat (3) step();
        mid();
        check("rst_valid", instr_valid_o, 1'b0);
        check("rst_rd", mem_rd_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_instr", instr_o, '0);
        check("rst_addr", mem_addr_o, '0);
        rst = 1'b0;
        step();

        // Basic fetch from 0 on both instances, ready held high.
        start_i = 1'b1; start_pc_i = '0; b_start = 1'b1; instr_ready_i = 1'b1;
        step();
        start_i = 1'b0; b_start = 1'b0;
        mid();
        check("lat_rd", mem_rd_o, 1'b1);
        check("lat_addr", mem_addr_o, 24'h0);
        check("b_lat_rd", b_mem_rd, 1'b1);
        for (int c = 2; c <= 18; c++) begin
            step();
            mid();
            if (c == 3) check("b_valid_c3", b_valid, 1'b0);
            if (c == 4) begin
                check("b_valid_c4", b_valid, 1'b1);
                check("b_instr_c4", b_instr, 64'hAABBCCDD11223344);
                check("b_pc_c4", b_instr_pc, 24'h0);
            end
            if (c == 9) check("valid_c9", instr_valid_o, 1'b0);
            if (c == 10) begin
                check("valid_c10", instr_valid_o, 1'b1);
                check("instr_c10", instr_o, 64'h1011121314151617);
                check("pc_c10", instr_pc_o, 24'h0);
            end
            if (c == 18) begin
                check("valid_c18", instr_valid_o, 1'b1);
                check("instr_c18", instr_o, 64'h18191A1B1C1D1E1F);
                check("pc_c18", instr_pc_o, 24'h8);
            end
        end
        step();
        go_idle();

        // Backpressure: ready low for 100 cycles.
        instr_ready_i = 1'b0; start_i = 1'b1; start_pc_i = '0;
        step();
        start_i = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            mid();
            if (mem_rd_o) cnt++;
            step();
        end
        check("bp_reads", cnt, 32);
        check("bp_valid", instr_valid_o, 1'b1);
        instr_ready_i = 1'b1;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            mid();
            if (mem_rd_o) cnt++;
            step();
        end
        check("bp_resume", cnt > 0, 1'b1);
        go_idle();

        // Redirect during beat 3 of the third assembly, two entries queued.
        instr_ready_i = 1'b0; start_i = 1'b1; start_pc_i = '0;
        step();
        start_i = 1'b0;
        for (int c = 2; c <= 20; c++) step();
        redirect_i = 1'b1; redirect_pc_i = 24'h40;
        mid();
        check("rd_pre_valid", instr_valid_o, 1'b1);
        step();
        redirect_i = 1'b0;
        mid();
        check("rd_valid_c21", instr_valid_o, 1'b0);
        for (int c = 22; c <= 30; c++) begin
            step();
            mid();
            if (c == 29) check("rd_valid_c29", instr_valid_o, 1'b0);
            if (c == 30) begin
                check("rd_valid_c30", instr_valid_o, 1'b1);
                check("rd_pc_c30", instr_pc_o, 24'h40);
                check("rd_instr_c30", instr_o, 64'h5051525354555657);
            end
        end
        step();
        go_idle();

        // Address wrap-around.
        instr_ready_i = 1'b1; start_i = 1'b1; start_pc_i = 24'hFFFFFC;
        step();
        start_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            mid();
            check("wrap_rd", mem_rd_o, 1'b1);
            check("wrap_addr", mem_addr_o, wrap_exp[c-1]);
            step();
        end
        step();
        mid();
        check("wrap_pc", instr_pc_o, 24'hFFFFFC);
        check("wrap_instr", instr_o, 64'h0C0D0E0F10111213);
        step();
        go_idle();

        // Reset while the queue is filling and an assembly is still completing.
        instr_ready_i = 1'b0; start_i = 1'b1; start_pc_i = 24'h100;
        step();
        start_i = 1'b0;
        for (int c = 2; c <= 33; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mid();
        check("mrst_valid", instr_valid_o, 1'b0);
        check("mrst_rd", mem_rd_o, 1'b0);
        check("mrst_busy", busy_o, 1'b0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            mid();
            if (mem_rd_o) cnt++;
        end
        check("mrst_no_rd", cnt, 0);

        // stop_i and redirect_i together: stop wins.
        step();
        instr_ready_i = 1'b1; start_i = 1'b1; start_pc_i = 24'h200;
        step();
        start_i = 1'b0;
        repeat (12) step();
        stop_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 24'h300;
        step();
        stop_i = 1'b0; redirect_i = 1'b0;
        mid();
        check("stop_busy", busy_o, 1'b0);
        check("stop_valid", instr_valid_o, 1'b0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_rd_o) cnt++;
            step();
            mid();
        end
        check("stop_no_rd", cnt, 0);

        // Randomized traffic against the model.
        low_phase = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if ((c % 64) == 0) low_phase = ($urandom_range(0, 2) == 0);
            rst           = ($urandom_range(0, 499) == 0);
            start_i       = ($urandom_range(0, 3) == 0);
            start_pc_i    = $urandom_range(0, 1) ? 24'($urandom) : 24'hFFFFF0 + 24'($urandom_range(0, 15));
            redirect_i    = ($urandom_range(0, 47) == 0);
            redirect_pc_i = $urandom_range(0, 3) == 0 ? 24'hFFFFFA : 24'($urandom);
            stop_i        = ($urandom_range(0, 299) == 0);
            instr_ready_i = low_phase ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
        end
        step();
        rst = 1'b0; start_i = 1'b0; redirect_i = 1'b0; stop_i = 1'b0;
        repeat (4) step();
        mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
